div_unit: RTL and testbench

- Multi-cycle 32-bit DIV/DIVU unit in the execute stage of the 5-stage MIPS pipeline.
- Runs restoring radix-2 division, one quotient bit per cycle.
- Holds the pipeline via a stall request consumed by the hazard unit, which converts it into stallF/stallD/stallE and flushM.
- Delivers {remainder, quotient} for the HI/LO write in the cycle the stall drops.

---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 125 ++++++++++++
 tb/tb_div_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared CPU constants for the execute-stage divider and the HI/LO register.
// Holds the divider state encoding, the default datapath width and the HI/LO write selects.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

  // HI/LO write source selects decoded by the hilo register
  localparam logic [1:0] HILO_SEL_NONE = 2'd0;
  localparam logic [1:0] HILO_SEL_MULT = 2'd1;
  localparam logic [1:0] HILO_SEL_DIV  = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] partRem,
  input  logic             dividendMsb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextRem,
  output logic             quotBit
);

  logic [WIDTH:0] shiftedS;
  logic [WIDTH:0] diffS;

  // Trial subtraction: since partRem < divisor, the top bit of diffS is set exactly on borrow
  always_comb begin
    shiftedS = {partRem, dividendMsb};
    diffS    = shiftedS - {1'b0, divisor};
    quotBit  = ~diffS[WIDTH];
    nextRem  = quotBit ? diffS[WIDTH-1:0] : shiftedS[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the execute stage; stalls the pipeline while iterating
// and pulses result_valid with {remainder, quotient} in the cycle the stall drops.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  divState_t        stateR;
  logic [CNT_W-1:0] cntR;
  logic [WIDTH-1:0] remR;
  logic [WIDTH-1:0] dvdR;
  logic [WIDTH-1:0] dvsR;
  logic             qSignR;
  logic             rSignR;

  logic [WIDTH-1:0] absAS;
  logic [WIDTH-1:0] absBS;
  logic [WIDTH-1:0] nextRemS;
  logic             qBitS;
  logic [WIDTH-1:0] finalQS;
  logic [WIDTH-1:0] finalRS;
  logic             lastIterS;
  logic             aNegS;
  logic             bNegS;

  function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] v, input logic neg);
    negIf = neg ? (~v + WIDTH'(1)) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .partRem    (remR),
    .dividendMsb(dvdR[WIDTH-1]),
    .divisor    (dvsR),
    .nextRem    (nextRemS),
    .quotBit    (qBitS)
  );

  // Operand magnitudes and sign-corrected results of the final iteration
  always_comb begin
    aNegS     = signed_div & a[WIDTH-1];
    bNegS     = signed_div & b[WIDTH-1];
    absAS     = negIf(a, aNegS);
    absBS     = negIf(b, bNegS);
    lastIterS = (cntR == CNT_W'(WIDTH - 1));
    finalQS   = negIf({dvdR[WIDTH-2:0], qBitS}, qSignR);
    finalRS   = negIf(nextRemS, rSignR);
  end

  assign stall = start & ~cancel & ((stateR == DIV_IDLE) | (stateR == DIV_BUSY));

  // Divider FSM; results are registered on entry to DONE so they are visible while result_valid is high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateR       <= DIV_IDLE;
      cntR         <= '0;
      remR         <= '0;
      dvdR         <= '0;
      dvsR         <= '0;
      qSignR       <= 1'b0;
      rSignR       <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      result_valid <= 1'b0;
    end else if (cancel) begin
      stateR       <= DIV_IDLE;
      result_valid <= 1'b0;
    end else begin
      case (stateR)
        DIV_IDLE: begin
          result_valid <= 1'b0;
          if (start) begin
            if (b == '0) begin
              quotient     <= {WIDTH{1'b1}};
              remainder    <= a;
              result_valid <= 1'b1;
              stateR       <= DIV_DONE;
            end else begin
              dvdR   <= absAS;
              dvsR   <= absBS;
              remR   <= '0;
              cntR   <= '0;
              qSignR <= aNegS ^ bNegS;
              rSignR <= aNegS;
              stateR <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          remR <= nextRemS;
          dvdR <= {dvdR[WIDTH-2:0], qBitS};
          cntR <= cntR + CNT_W'(1);
          if (lastIterS) begin
            quotient     <= finalQS;
            remainder    <= finalRS;
            result_valid <= 1'b1;
            stateR       <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          result_valid <= 1'b0;
          stateR       <= DIV_IDLE;
        end
        default: begin
          result_valid <= 1'b0;
          stateR       <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and lightly randomised bench for div_unit with a result scoreboard.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] sbQ[$];
  logic [31:0] lastQ;
  logic [31:0] lastR;

  always #5 clk = ~clk;

  div_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .signed_div  (signed_div),
    .cancel      (cancel),
    .a           (a),
    .b           (b),
    .stall       (stall),
    .result_valid(result_valid),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every result pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 && result_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpectedValid: observed result_valid=1 q=%0h r=%0h expected no result", quotient, remainder);
      end else begin
        logic [63:0] exp;
        exp = sbQ.pop_front();
        check("quotient", {32'd0, quotient}, {32'd0, exp[63:32]});
        check("remainder", {32'd0, remainder}, {32'd0, exp[31:0]});
      end
    end
  end

  task automatic doDiv(input logic [31:0] av, input logic [31:0] bv, input logic sd,
                       input int expStall, input logic [31:0] eq, input logic [31:0] er);
    int n;
    sbQ.push_back({eq, er});
    lastQ = eq;
    lastR = er;
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    signed_div = sd;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stallCycles", 64'(n), 64'(expStall));
    check("validAtDrop", {63'd0, result_valid}, 64'd1);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] eq;
    logic [31:0] er;

    resetn = 1'b0;
    start = 1'b0;
    signed_div = 1'b0;
    cancel = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rstQuotient", {32'd0, quotient}, 64'd0);
    check("rstRemainder", {32'd0, remainder}, 64'd0);
    check("rstValid", {63'd0, result_valid}, 64'd0);
    check("rstStall", {63'd0, stall}, 64'd0);
    resetn = 1'b1;

    doDiv(32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);
    doDiv(32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    doDiv(32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1);
    doDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0);
    doDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 32'd0, 32'h8000_0000);
    doDiv(32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd5);
    doDiv(32'hFFFF_FFFB, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Cancel in the tenth BUSY cycle: no result, outputs hold the previous values
    @(negedge clk);
    start = 1'b1;
    a = 32'd100;
    b = 32'd7;
    signed_div = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1;
    check("stallOnCancel", {63'd0, stall}, 64'd0);
    @(negedge clk);
    cancel = 1'b0;
    start = 1'b0;
    #1;
    check("validAfterCancel", {63'd0, result_valid}, 64'd0);
    check("holdQuotient", {32'd0, quotient}, {32'd0, lastQ});
    check("holdRemainder", {32'd0, remainder}, {32'd0, lastR});
    repeat (3) @(negedge clk);
    doDiv(32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0);

    // Back-to-back divides
    doDiv(32'd20, 32'd3, 1'b0, 33, 32'd6, 32'd2);
    doDiv(32'hFFFF_FFFF, 32'h10, 1'b0, 33, 32'h0FFF_FFFF, 32'hF);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = i[0];
      if (i >= 4) rb = {28'd0, rb[3:0]};
      if (rb == 32'd0) rb = 32'd3;
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ra = 32'd1;
      if (rs) begin
        eq = $signed(ra) / $signed(rb);
        er = $signed(ra) % $signed(rb);
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      doDiv(ra, rb, rs, 33, eq, er);
    end

    // Reset while BUSY discards the operation
    @(negedge clk);
    start = 1'b1;
    a = 32'd20;
    b = 32'd3;
    signed_div = 1'b0;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    start = 1'b0;
    #1;
    check("midRstQuotient", {32'd0, quotient}, 64'd0);
    check("midRstRemainder", {32'd0, remainder}, 64'd0);
    check("midRstValid", {63'd0, result_valid}, 64'd0);
    check("midRstStall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    doDiv(32'd100, 32'hFFFF_FFF9, 1'b1, 33, 32'hFFFF_FFF2, 32'd2);

    repeat (3) @(negedge clk);
    check("sbEmpty", 64'(sbQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
